// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Optional frame checksum is enabled with the LOADER_CHECKSUM_EN macro.
package program_loader_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   localparam logic [7:0] CMD_INSTR = 8'hA5;
   localparam logic [7:0] CMD_DATA  = 8'h5A;
   localparam logic [7:0] CMD_RUN   = 8'hC3;
   localparam logic [7:0] CMD_ABORT = 8'hFF;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_CNT,
      ST_DATA_H,
      ST_DATA_L,
      ST_WRITE,
      ST_RUN_CLR,
      ST_RUN,
      ST_HALTED
`ifdef LOADER_CHECKSUM_EN
      ,ST_CSUM
`endif
   } state_t;

   typedef enum logic {
      MEM_INSTR,
      MEM_DATA
   } mem_sel_t;

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader for instruction/data memories plus run sequencer.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per load frame.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int CLR_CYCLES = 4
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              core_done,
   output logic              test_normal,
   output logic              core_clr,
   output logic              ext_instr_we,
   output logic [ADDR_W-1:0] ext_instr_addr,
   output logic [DATA_W-1:0] ext_instr_data,
   output logic              ext_data_we,
   output logic [ADDR_W-1:0] ext_data_addr,
   output logic [DATA_W-1:0] ext_data_data,
   output logic              busy,
   output logic              run_done,
   output logic              err
);

   localparam int CLR_W = $clog2(CLR_CYCLES + 1);

   state_t            r_state;
   state_t            w_next;
   mem_sel_t          r_target;
   logic [7:0]        r_addr_hi;
   logic [ADDR_W-1:0] r_addr;
   logic [8:0]        r_count;
   logic [7:0]        r_word_hi;
   logic [CLR_W-1:0]  r_clr_cnt;
   logic              r_run_done;
   logic              r_err;
   logic [ADDR_W-1:0] r_instr_addr;
   logic [DATA_W-1:0] r_instr_data;
   logic [ADDR_W-1:0] r_data_addr;
   logic [DATA_W-1:0] r_data_data;
   logic              w_xfer;
   logic              w_err_set;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        r_csum;
`endif

   assign w_xfer = in_valid & in_ready;

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      w_next    = r_state;
      w_err_set = 1'b0;
      case (r_state)
         ST_IDLE, ST_HALTED: begin
            if (w_xfer) begin
               case (in_data)
                  CMD_INSTR, CMD_DATA: w_next = ST_ADDR_H;
                  CMD_RUN:             w_next = ST_RUN_CLR;
                  CMD_ABORT:           w_next = r_state;
                  default:             w_err_set = 1'b1;
               endcase
            end
         end
         ST_ADDR_H: if (w_xfer) w_next = ST_ADDR_L;
         ST_ADDR_L: if (w_xfer) w_next = ST_CNT;
         ST_CNT:    if (w_xfer) w_next = ST_DATA_H;
         ST_DATA_H: if (w_xfer) w_next = ST_DATA_L;
         ST_DATA_L: if (w_xfer) w_next = ST_WRITE;
         ST_WRITE: begin
            if (r_count == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
               w_next = ST_CSUM;
`else
               w_next = ST_IDLE;
`endif
            end else begin
               w_next = ST_DATA_H;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (w_xfer) begin
               w_next    = ST_IDLE;
               w_err_set = (in_data != r_csum);
            end
         end
`endif
         ST_RUN_CLR: if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) w_next = ST_RUN;
         ST_RUN: begin
            // A simultaneous done beats abort so the halted core stays observable.
            if (core_done)                            w_next = ST_HALTED;
            else if (w_xfer && in_data == CMD_ABORT)  w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state      <= ST_IDLE;
         r_target     <= MEM_INSTR;
         r_addr_hi    <= '0;
         r_addr       <= '0;
         r_count      <= '0;
         r_word_hi    <= '0;
         r_clr_cnt    <= '0;
         r_run_done   <= 1'b0;
         r_err        <= 1'b0;
         r_instr_addr <= '0;
         r_instr_data <= '0;
         r_data_addr  <= '0;
         r_data_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
         r_csum       <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (w_err_set) r_err <= 1'b1;
         r_clr_cnt <= (r_state == ST_RUN_CLR) ? r_clr_cnt + 1'b1 : '0;
         if (r_state == ST_RUN && w_next == ST_HALTED) r_run_done <= 1'b1;

         case (r_state)
            ST_IDLE, ST_HALTED: begin
               if (w_xfer) begin
                  if (in_data == CMD_INSTR) r_target <= MEM_INSTR;
                  if (in_data == CMD_DATA)  r_target <= MEM_DATA;
                  if (in_data == CMD_RUN)   r_run_done <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  r_csum <= in_data;
`endif
               end
            end
            ST_ADDR_H: if (w_xfer) r_addr_hi <= in_data;
            ST_ADDR_L: if (w_xfer) r_addr <= ADDR_W'({r_addr_hi, in_data});
            ST_CNT:    if (w_xfer) r_count <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            ST_DATA_H: if (w_xfer) r_word_hi <= in_data;
            ST_DATA_L: begin
               if (w_xfer) begin
                  if (r_target == MEM_INSTR) begin
                     r_instr_addr <= r_addr;
                     r_instr_data <= DATA_W'({r_word_hi, in_data});
                  end else begin
                     r_data_addr  <= r_addr;
                     r_data_data  <= DATA_W'({r_word_hi, in_data});
                  end
               end
            end
            ST_WRITE: begin
               r_addr  <= r_addr + 1'b1;
               r_count <= r_count - 1'b1;
            end
            default: ;
         endcase

`ifdef LOADER_CHECKSUM_EN
         if (w_xfer && (r_state == ST_ADDR_H || r_state == ST_ADDR_L || r_state == ST_CNT ||
                        r_state == ST_DATA_H || r_state == ST_DATA_L))
            r_csum <= r_csum ^ in_data;
`endif
      end
   end

   assign in_ready       = (r_state != ST_WRITE) && (r_state != ST_RUN_CLR);
   assign test_normal    = !(r_state == ST_RUN_CLR || r_state == ST_RUN || r_state == ST_HALTED);
   assign core_clr       = !(r_state == ST_RUN || r_state == ST_HALTED);
   assign busy           = (r_state != ST_IDLE) && (r_state != ST_HALTED);
   assign ext_instr_we   = (r_state == ST_WRITE) && (r_target == MEM_INSTR);
   assign ext_data_we    = (r_state == ST_WRITE) && (r_target == MEM_DATA);
   assign ext_instr_addr = r_instr_addr;
   assign ext_instr_data = r_instr_data;
   assign ext_data_addr  = r_data_addr;
   assign ext_data_data  = r_data_data;
   assign run_done       = r_run_done;
   assign err            = r_err;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream loader that sits directly upstream of the single-cycle RISC core and drives its external load ports: test_normal, ext_instr_*, ext_data_*, and the core clear.
- Receives framed commands over a valid/ready byte interface, typically from a UART receiver.
- Writes instruction memory or data memory with auto-incrementing addresses.
- Launches a program run and reports when the core asserts done.

Parameters:
- ADDR_W, 16, width of memory address buses.
- DATA_W, 16, width of memory data words; each word arrives as 2 bytes.
- CLR_CYCLES, 4, number of cycles core_clr is held high at run start (minimum 1).
- CMD_INSTR, 8'hA5, command byte: load instruction memory.
- CMD_DATA, 8'h5A, command byte: load data memory.
- CMD_RUN, 8'hC3, command byte: start execution.
- CMD_ABORT, 8'hFF, command byte: abort a run in progress.

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts in_data this cycle when in_valid=1.
- core_done  in  1  core halted (HLT executed).
- test_normal  out  1  1 = memories driven by loader, 0 = core runs.
- core_clr  out  1  active-high clear to the core.
- ext_instr_we  out  1  instruction memory write strobe.
- ext_instr_addr  out  ADDR_W  instruction memory address.
- ext_instr_data  out  DATA_W  instruction memory write data.
- ext_data_we  out  1  data memory write strobe.
- ext_data_addr  out  ADDR_W  data memory address.
- ext_data_data  out  DATA_W  data memory write data.
- busy  out  1  loader is in any state other than IDLE or HALTED.
- run_done  out  1  level; core reached done since the last CMD_RUN.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (clr_n=0, asynchronous) puts the block in IDLE and forces:
  - test_normal=1, core_clr=1.
  - Both we=0, all addr/data=0.
  - busy=0, run_done=0, err=0, in_ready=1.
- A byte transfers on a rising clk when in_valid=1 and in_ready=1.
- in_ready=0 only in WRITE and RUN_CLR.
- Frame format: cmd, addr_hi, addr_lo, count (0 means 256 words), then count x {word_hi, word_lo}. All multi-byte fields are MSB first.
- States: IDLE, ADDR_H, ADDR_L, CNT, DATA_H, DATA_L, WRITE, RUN_CLR, RUN, HALTED.
- IDLE/HALTED:
  - CMD_INSTR or CMD_DATA latches the target memory and goes to ADDR_H.
  - CMD_RUN goes to RUN_CLR.
  - Any other byte sets err and stays in the current state; CMD_ABORT is ignored.
- ADDR_H -> ADDR_L -> CNT -> DATA_H -> DATA_L: one accepted byte per transition.
- DATA_L -> WRITE; WRITE lasts exactly 1 cycle.
  - The selected ext_*_we=1 with the current addr and assembled word. The other memory's we stays 0.
  - Next cycle: addr increments modulo 2^ADDR_W (0xFFFF wraps to 0x0000) and count decrements.
  - If the remaining count reaches 0, go to IDLE; otherwise go to DATA_H.
  - addr/data outputs hold their last value after WRITE.
- Load states keep test_normal=1 and core_clr=1.
- RUN_CLR:
  - test_normal=0, core_clr=1 for exactly CLR_CYCLES cycles, then RUN.
  - Entering RUN_CLR clears run_done.
- RUN:
  - test_normal=0, core_clr=0, in_ready=1.
  - core_done=1 moves to HALTED on the next edge.
  - An accepted CMD_ABORT moves to IDLE, restoring test_normal=1 and core_clr=1.
  - All other bytes are consumed and dropped without setting err.
  - If core_done and CMD_ABORT occur in the same cycle, core_done wins.
- HALTED:
  - run_done=1, test_normal=0, core_clr=0 (core state stays visible).
  - A new command byte is handled as in IDLE.
  - CMD_INSTR/CMD_DATA from HALTED sets test_normal=1 and core_clr=1 on the transition.
- Reset mid-frame: the partial frame is discarded; no write strobe is emitted.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - Each load frame carries one extra byte after the last word.
  - That byte must equal the XOR of all frame bytes from cmd through the last word_lo; it is checked in a CSUM state.
  - A mismatch sets err.
  - Words are already written regardless of the checksum result.
- When undefined: no CSUM state; the frame ends after the last word.

Decomposition:
- Package program_loader_pkg holds:
  - the state enum;
  - CMD_* constants;
  - ADDR_W/DATA_W defaults.
- No sub-module is needed. The frame parser and run sequencer share one FSM.
- The CLR_CYCLES counter is inline.

Test Plan:
- Instruction load:
  - Stimulus: A5 00 00 02 19 00 E0 20.
  - Response: ext_instr_we pulses twice — addr 0x0000 data 0x1900, then addr 0x0001 data 0xE020. ext_data_we stays 0. busy then returns to 0.
- Data load:
  - Stimulus: 5A 00 25 01 00 47.
  - Response: one ext_data_we pulse, addr 0x0025 data 0x0047. err=0.
- Address wrap:
  - Stimulus: A5 FF FF 02 + 4 bytes.
  - Response: writes land at 0xFFFF then 0x0000.
- Run:
  - Stimulus: C3, core_done raised 10 cycles after entering RUN.
  - Response: core_clr high 4 cycles with test_normal=0, then released. run_done=1 on the cycle after core_done.
  - Follow-up: a byte 0x12 sent during RUN leaves err=0.
- Errors and abort:
  - Stimulus: byte 0x33 in IDLE.
  - Response: err=1 sticky.
  - Stimulus: C3 then FF during RUN.
  - Response: return to IDLE with test_normal=1, core_clr=1, run_done=0.
- Reset mid-frame:
  - Stimulus: A5 00 10 01 AB, then clr_n low for 1 cycle, then the final byte.
  - Response: no we pulse; all outputs at reset values. The following byte is treated as a command.
  - Checksum (LOADER_CHECKSUM_EN): frame with wrong XOR byte -> err=1.
